// File: rtl/r2sdf_butterfly_stage_if.sv
// Stream, twiddle-ROM and output signals of one R2SDF butterfly stage.
// The master side feeds samples and twiddles; the stage itself is the slave.
interface r2sdf_butterfly_stage_if #(
    parameter int N     = 3,
    parameter int STAGE = 1,
    parameter int DW    = 16,
    parameter int TW    = 16
);
    localparam int AW = (STAGE > 1) ? STAGE - 1 : 1;

    logic                 start_ip;
    logic signed [DW-1:0] ip_re;
    logic signed [DW-1:0] ip_im;
    logic        [AW-1:0] tw_addr;
    logic signed [TW-1:0] tw_re;
    logic signed [TW-1:0] tw_im;
    logic signed [DW-1:0] op_re;
    logic signed [DW-1:0] op_im;
    logic                 start_op;
    logic        [N-1:0]  out_idx;

    modport master (
        output start_ip, ip_re, ip_im, tw_re, tw_im,
        input  tw_addr, op_re, op_im, start_op, out_idx
    );

    modport slave (
        input  start_ip, ip_re, ip_im, tw_re, tw_im,
        output tw_addr, op_re, op_im, start_op, out_idx
    );
endinterface

// File: rtl/r2sdf_butterfly_stage.sv
// One radix-2 single-path delay-feedback FFT butterfly stage with span 2^(STAGE-1),
// plus the bit-reversed frame position of each output sample.
module r2sdf_butterfly_stage #(
    parameter int N     = 3,
    parameter int STAGE = 1,
    parameter int DW    = 16,
    parameter int TW    = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    r2sdf_butterfly_stage_if.slave       bus
);
    localparam int D  = 1 << (STAGE - 1);
    localparam int KW = STAGE;
    localparam int AW = (STAGE > 1) ? STAGE - 1 : 1;
    localparam int PW = DW + TW;
    localparam int XW = DW + 3;
    localparam logic signed [XW-1:0] SAT_MAX = XW'((1 << (DW - 1)) - 1);
    localparam logic signed [XW-1:0] SAT_MIN = -SAT_MAX - XW'(1);

    function automatic logic signed [DW-1:0] half_sat(input logic signed [XW-1:0] v);
        logic signed [XW-1:0] h;
        h = v >>> 1;
        if (h > SAT_MAX)      return SAT_MAX[DW-1:0];
        else if (h < SAT_MIN) return SAT_MIN[DW-1:0];
        else                  return h[DW-1:0];
    endfunction

    function automatic logic [N-1:0] bitrev(input logic [N-1:0] v);
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) r[i] = v[N-1-i];
        return r;
    endfunction

    logic [KW-1:0]        cnt;
    logic                 running;
    logic [KW-1:0]        k_cur;
    logic                 active;
    logic                 phase_b;
    logic                 start_nxt;

    logic signed [DW-1:0] dl_re [D];
    logic signed [DW-1:0] dl_im [D];
    logic signed [DW-1:0] head_re;
    logic signed [DW-1:0] head_im;

    logic signed [PW:0]   br_x, bi_x, wr_x, wi_x;
    logic signed [PW:0]   prod_re, prod_im;
    logic signed [XW-1:0] t_re, t_im, a_re, a_im;
    logic signed [DW-1:0] sum_re, sum_im, diff_re, diff_im;
    logic signed [DW-1:0] push_re, push_im;

    logic signed [DW-1:0] op_re_p0, op_im_p0;
    logic                 start_op_p0;
    logic [N-1:0]         pos_p0;
    logic [N-1:0]         pos_nxt;
    logic [N-1:0]         out_idx_p0;

    // A start_ip forces k = 0 for the sample presented with it, even mid-block.
    assign k_cur     = bus.start_ip ? '0 : cnt;
    assign active    = bus.start_ip | running;
    assign phase_b   = k_cur[KW-1];
    assign start_nxt = (k_cur == KW'(D));

    generate
        if (STAGE > 1) begin : g_addr
            assign bus.tw_addr = k_cur[AW-1:0];
        end else begin : g_addr1
            assign bus.tw_addr = '0;
        end
    endgenerate

    assign head_re = dl_re[D-1];
    assign head_im = dl_im[D-1];

    // Complex multiply b * W at full precision, floor-scaled back by the Q1.(TW-2) unit.
    assign br_x    = (PW+1)'(bus.ip_re);
    assign bi_x    = (PW+1)'(bus.ip_im);
    assign wr_x    = (PW+1)'(bus.tw_re);
    assign wi_x    = (PW+1)'(bus.tw_im);
    assign prod_re = br_x * wr_x - bi_x * wi_x;
    assign prod_im = br_x * wi_x + bi_x * wr_x;
    assign t_re    = XW'(prod_re >>> (TW - 2));
    assign t_im    = XW'(prod_im >>> (TW - 2));

    assign a_re    = XW'(head_re);
    assign a_im    = XW'(head_im);
    assign sum_re  = half_sat(a_re + t_re);
    assign sum_im  = half_sat(a_im + t_im);
    assign diff_re = half_sat(a_re - t_re);
    assign diff_im = half_sat(a_im - t_im);

    assign push_re = phase_b ? diff_re : bus.ip_re;
    assign push_im = phase_b ? diff_im : bus.ip_im;
    assign pos_nxt = start_nxt ? '0 : pos_p0 + N'(1);

    // Stage boundary p0: output, delay line and block/frame counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt         <= '0;
            running     <= 1'b0;
            op_re_p0    <= '0;
            op_im_p0    <= '0;
            start_op_p0 <= 1'b0;
            pos_p0      <= '0;
            out_idx_p0  <= '0;
            for (int i = 0; i < D; i++) begin
                dl_re[i] <= '0;
                dl_im[i] <= '0;
            end
        end else if (active) begin
            cnt         <= k_cur + KW'(1);
            running     <= 1'b1;
            op_re_p0    <= phase_b ? sum_re : head_re;
            op_im_p0    <= phase_b ? sum_im : head_im;
            start_op_p0 <= start_nxt;
            pos_p0      <= pos_nxt;
            out_idx_p0  <= bitrev(pos_nxt);
            dl_re[0]    <= push_re;
            dl_im[0]    <= push_im;
            for (int i = 1; i < D; i++) begin
                dl_re[i] <= dl_re[i-1];
                dl_im[i] <= dl_im[i-1];
            end
        end else begin
            start_op_p0 <= 1'b0;
        end
    end

    assign bus.op_re    = op_re_p0;
    assign bus.op_im    = op_im_p0;
    assign bus.start_op = start_op_p0;
    assign bus.out_idx  = out_idx_p0;

endmodule

// File: tb/tb_r2sdf_butterfly_stage.sv
// Directed bench for r2sdf_butterfly_stage: three stage instances (spans 1, 2, 4)
// with hand-computed outputs, saturation, bit-reversed index, reset and resync.
module tb_r2sdf_butterfly_stage;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    r2sdf_butterfly_stage_if #(.N(3), .STAGE(1), .DW(16), .TW(16)) if1 ();
    r2sdf_butterfly_stage_if #(.N(3), .STAGE(2), .DW(16), .TW(16)) if2 ();
    r2sdf_butterfly_stage_if #(.N(3), .STAGE(3), .DW(16), .TW(16)) if3 ();

    r2sdf_butterfly_stage #(.N(3), .STAGE(1), .DW(16), .TW(16)) dut1 (.clk(clk), .rst(rst), .bus(if1));
    r2sdf_butterfly_stage #(.N(3), .STAGE(2), .DW(16), .TW(16)) dut2 (.clk(clk), .rst(rst), .bus(if2));
    r2sdf_butterfly_stage #(.N(3), .STAGE(3), .DW(16), .TW(16)) dut3 (.clk(clk), .rst(rst), .bus(if3));

    // Twiddle ROMs: W^k = exp(-j*2*pi*k/2D) in Q1.14.
    assign if1.tw_re = 16'sd16384;
    assign if1.tw_im = 16'sd0;

    always_comb begin
        if2.tw_re = 16'sd16384;
        if2.tw_im = 16'sd0;
        if (if2.tw_addr == 1'b1) begin
            if2.tw_re = 16'sd0;
            if2.tw_im = -16'sd16384;
        end
    end

    always_comb begin
        if3.tw_re = 16'sd16384;
        if3.tw_im = 16'sd0;
        case (if3.tw_addr)
            2'd1: begin if3.tw_re = 16'sd11585;  if3.tw_im = -16'sd11585; end
            2'd2: begin if3.tw_re = 16'sd0;      if3.tw_im = -16'sd16384; end
            2'd3: begin if3.tw_re = -16'sd11585; if3.tw_im = -16'sd11585; end
            default: ;
        endcase
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv1(input logic s, input int re, input int im);
        if1.start_ip = s; if1.ip_re = 16'(re); if1.ip_im = 16'(im);
    endtask
    task automatic drv2(input logic s, input int re, input int im);
        if2.start_ip = s; if2.ip_re = 16'(re); if2.ip_im = 16'(im);
    endtask
    task automatic drv3(input logic s, input int re, input int im);
        if3.start_ip = s; if3.ip_re = 16'(re); if3.ip_im = 16'(im);
    endtask

    int exp_idx [8] = '{0, 4, 2, 6, 1, 5, 3, 7};
    int s3_re   [8] = '{32767, 32767, 32767, 16383, 0, -6786, 0, 16383};
    int s3_im   [8] = '{32767, 16383, 0, -6786, 0, 16383, 32767, 32767};

    initial begin
        drv1(1'b0, 0, 0);
        drv2(1'b0, 0, 0);
        drv3(1'b0, 0, 0);

        // Reset state
        tick();
        tick();
        chk("rst_op_re1", int'(if1.op_re), 0);
        chk("rst_start1", int'(if1.start_op), 0);
        chk("rst_idx1", int'(if1.out_idx), 0);
        chk("rst_op_im3", int'(if3.op_im), 0);
        rst = 1'b0;

        // Span 1: (100,0) then (50,0)
        drv1(1'b1, 100, 0);
        tick();
        chk("s1_first_op", int'(if1.op_re), 0);
        chk("s1_first_start", int'(if1.start_op), 0);
        drv1(1'b0, 50, 0);
        tick();
        chk("s1_sum_re", int'(if1.op_re), 75);
        chk("s1_sum_im", int'(if1.op_im), 0);
        chk("s1_sum_start", int'(if1.start_op), 1);
        chk("s1_sum_idx", int'(if1.out_idx), 0);
        drv1(1'b0, 0, 0);
        tick();
        chk("s1_diff_re", int'(if1.op_re), 25);
        chk("s1_diff_start", int'(if1.start_op), 0);

        // Span 2: (100,0) (0,100) (20,0) (40,0)
        drv2(1'b1, 100, 0);
        tick();
        chk("s2_a0_re", int'(if2.op_re), 0);
        drv2(1'b0, 0, 100);
        tick();
        chk("s2_a1_im", int'(if2.op_im), 0);
        chk("s2_a1_start", int'(if2.start_op), 0);
        drv2(1'b0, 20, 0);
        tick();
        chk("s2_sum0_re", int'(if2.op_re), 60);
        chk("s2_sum0_im", int'(if2.op_im), 0);
        chk("s2_sum0_start", int'(if2.start_op), 1);
        drv2(1'b0, 40, 0);
        tick();
        chk("s2_sum1_re", int'(if2.op_re), 0);
        chk("s2_sum1_im", int'(if2.op_im), 30);
        chk("s2_sum1_start", int'(if2.start_op), 0);
        drv2(1'b0, 0, 0);
        tick();
        chk("s2_diff0_re", int'(if2.op_re), 40);
        chk("s2_diff0_im", int'(if2.op_im), 0);
        tick();
        chk("s2_diff1_re", int'(if2.op_re), 0);
        chk("s2_diff1_im", int'(if2.op_im), 70);

        // Span 4: saturation and bit-reversed index over a full frame
        drv3(1'b1, 32767, 32767);
        tick();
        drv3(1'b0, 32767, 32767);
        tick();
        tick();
        tick();
        chk("s3_phaseA_re", int'(if3.op_re), 0);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk($sformatf("s3_re_%0d", i), int'(if3.op_re), s3_re[i]);
            chk($sformatf("s3_im_%0d", i), int'(if3.op_im), s3_im[i]);
            chk($sformatf("s3_idx_%0d", i), int'(if3.out_idx), exp_idx[i]);
            chk($sformatf("s3_start_%0d", i), int'(if3.start_op), (i == 0) ? 1 : 0);
        end
        tick();
        chk("s3_wrap_start", int'(if3.start_op), 1);
        chk("s3_wrap_idx", int'(if3.out_idx), 0);
        chk("s3_wrap_re", int'(if3.op_re), 32767);

        // Reset asserted in phase B
        drv2(1'b1, 10, 0);
        tick();
        drv2(1'b0, 10, 0);
        tick();
        drv2(1'b0, 20, 0);
        tick();
        chk("rb_sum_re", int'(if2.op_re), 15);
        chk("rb_sum_start", int'(if2.start_op), 1);
        rst = 1'b1;
        #1;
        chk("rb_async_re", int'(if2.op_re), 0);
        chk("rb_async_start", int'(if2.start_op), 0);
        chk("rb_async_idx", int'(if2.out_idx), 0);
        chk("rb_async_re3", int'(if3.op_re), 0);
        #2;
        rst = 1'b0;
        drv2(1'b0, 7, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("rb_idle_start_%0d", i), int'(if2.start_op), 0);
            chk($sformatf("rb_idle_re_%0d", i), int'(if2.op_re), 0);
        end
        drv2(1'b1, 7, 0);
        tick();
        drv2(1'b0, 7, 0);
        tick();
        chk("rb_restart_k1", int'(if2.start_op), 0);
        tick();
        chk("rb_restart_start", int'(if2.start_op), 1);
        chk("rb_restart_re", int'(if2.op_re), 7);

        // Resync: start_ip again at k = 1
        drv2(1'b1, 8, 0);
        tick();
        drv2(1'b1, 4, 0);
        tick();
        drv2(1'b0, 6, 0);
        tick();
        chk("rs_k1_start", int'(if2.start_op), 0);
        drv2(1'b0, 2, 0);
        tick();
        chk("rs_k2_start", int'(if2.start_op), 1);
        chk("rs_k2_re", int'(if2.op_re), 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
